// File: rtl/distortion_pipe.sv
// distortion_pipe: smoothed gain followed by bypass/hard/soft/asymmetric clip
// with a saturating count of clipped output samples; 4-cycle fixed latency.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid         input sample strobe (no backpressure)
//   in_sample        signed input sample, DATA_W bits
//   gain_target      signed target gain, Q(FRAC_BITS)
//   mode             0 bypass, 1 hard, 2 soft, 3 asymmetric (per sample)
//   clear_count      synchronous clear of clip_count (wins over increment)
//   out_valid        out_sample strobe
//   out_sample       signed shaped sample, holds while out_valid = 0
//   gain_now         current smoothed gain
//   clip_count       saturating clipped-sample count
//
// Build option: define DISTORTION_PIPE_SOFTCLIP_EN to build the cubic soft
// clip for mode 2; without it mode 2 behaves as the hard clip.

module distortion_pipe #(
   parameter int DATA_W     = 16,
   parameter int FRAC_BITS  = 12,
   parameter int GAIN_W     = 16,
   parameter int RAMP_SHIFT = 6,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_sample,
   input  logic signed [GAIN_W-1:0] gain_target,
   input  logic [1:0]               mode,
   input  logic                     clear_count,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_sample,
   output logic signed [GAIN_W-1:0] gain_now,
   output logic [CNT_W-1:0]         clip_count
);

   localparam int P_W = DATA_W + GAIN_W;
   localparam int D_W = GAIN_W + 1;
`ifdef DISTORTION_PIPE_SOFTCLIP_EN
   // x clamped to +/-F needs FRAC_BITS+2 signed bits; products need twice that
   localparam int XC_W = FRAC_BITS + 2;
   localparam int M_W  = 2 * XC_W;
`endif

   localparam logic signed [P_W-1:0] F_P =
      P_W'(longint'(1) <<< FRAC_BITS);
   localparam logic signed [P_W-1:0] H_P = F_P - P_W'(1);
   localparam logic signed [P_W-1:0] HALF_P = F_P >>> 1;
   localparam logic signed [GAIN_W-1:0] F_G =
      GAIN_W'(longint'(1) <<< FRAC_BITS);

   typedef enum logic [1:0] {
      M_BYP  = 2'd0,
      M_HARD = 2'd1,
      M_SOFT = 2'd2,
      M_ASYM = 2'd3
   } mode_e;

   // returns {clip, y}
   function automatic logic [P_W:0] f_clamp(
      input logic signed [P_W-1:0] i_x,
      input logic signed [P_W-1:0] i_lo,
      input logic signed [P_W-1:0] i_hi
   );
      logic [P_W:0] v;
      if (i_x > i_hi) begin
         v = {1'b1, i_hi};
      end else if (i_x < i_lo) begin
         v = {1'b1, i_lo};
      end else begin
         v = {1'b0, i_x};
      end
      return v;
   endfunction

   // ---------------- gain smoother ----------------
   logic signed [GAIN_W-1:0] r_g;
   logic signed [D_W-1:0]    w_d;
   logic signed [D_W-1:0]    w_sh;
   logic signed [D_W-1:0]    w_step;
   logic signed [GAIN_W-1:0] w_g_nxt;

   always_comb begin
      w_d    = D_W'(gain_target) - D_W'(r_g);
      w_sh   = w_d >>> RAMP_SHIFT;
      w_step = w_sh;
      // small positive error would stall at 0; force a unit step
      if (w_sh == '0 && w_d != '0) begin
         w_step = w_d[D_W-1] ? '1 : D_W'(1);
      end
      w_g_nxt = GAIN_W'(D_W'(r_g) + w_step);
   end

   // ---------------- S1: multiply ----------------
   logic signed [P_W-1:0]    w_p;
   logic                     r_s1_v;
   logic signed [P_W-1:0]    r_s1_p;
   mode_e                    r_s1_mode;
   logic signed [DATA_W-1:0] r_s1_raw;

   assign w_p = P_W'(in_sample) * P_W'(r_g);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_g    <= F_G;
         r_s1_v <= 1'b0;
      end else begin
         r_s1_v <= in_valid;
         if (in_valid) begin
            r_g <= w_g_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         r_s1_p    <= w_p;
         r_s1_mode <= mode_e'(mode);
         r_s1_raw  <= in_sample;
      end
   end

   // ---------------- S2: rescale, square ----------------
   logic signed [P_W-1:0]    w_x;
   logic                     r_s2_v;
   logic signed [P_W-1:0]    r_s2_x;
   mode_e                    r_s2_mode;
   logic signed [DATA_W-1:0] r_s2_raw;

   assign w_x = r_s1_p >>> FRAC_BITS;

`ifdef DISTORTION_PIPE_SOFTCLIP_EN
   logic signed [XC_W-1:0] w_xc;
   logic signed [M_W-1:0]  w_sq;
   logic signed [XC_W-1:0] w_x2;
   logic signed [XC_W-1:0] r_s2_xc;
   logic signed [XC_W-1:0] r_s2_x2;

   always_comb begin
      // bound x before squaring so x2 never exceeds F
      if (w_x > F_P) begin
         w_xc = XC_W'(F_P);
      end else if (w_x < -F_P) begin
         w_xc = XC_W'(-F_P);
      end else begin
         w_xc = XC_W'(w_x);
      end
      w_sq = M_W'(w_xc) * M_W'(w_xc);
      w_x2 = XC_W'(w_sq >>> FRAC_BITS);
   end

   always_ff @(posedge clk) begin
      if (r_s1_v) begin
         r_s2_xc <= w_xc;
         r_s2_x2 <= w_x2;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_v <= 1'b0;
      end else begin
         r_s2_v <= r_s1_v;
      end
   end

   always_ff @(posedge clk) begin
      if (r_s1_v) begin
         r_s2_x    <= w_x;
         r_s2_mode <= r_s1_mode;
         r_s2_raw  <= r_s1_raw;
      end
   end

   // ---------------- S3: shaping ----------------
   logic signed [P_W-1:0]    w_y;
   logic                     w_clip;
   logic                     r_s3_v;
   logic signed [DATA_W-1:0] r_s3_y;
   logic                     r_s3_clip;

`ifdef DISTORTION_PIPE_SOFTCLIP_EN
   logic signed [M_W-1:0] w_cube;
   logic signed [M_W-1:0] w_x3;
   logic signed [M_W-1:0] w_soft;

   always_comb begin
      w_cube = M_W'(r_s2_x2) * M_W'(r_s2_xc);
      w_x3   = w_cube >>> FRAC_BITS;
      // (3x - x^3) / 2
      w_soft = ((M_W'(r_s2_xc) <<< 1) + M_W'(r_s2_xc) - w_x3) >>> 1;
   end
`endif

   always_comb begin
      w_y    = P_W'(r_s2_raw);
      w_clip = 1'b0;
      unique case (r_s2_mode)
         M_BYP: begin
            w_y    = P_W'(r_s2_raw);
            w_clip = 1'b0;
         end
         M_HARD: begin
            {w_clip, w_y} = f_clamp(r_s2_x, -F_P, H_P);
         end
         M_SOFT: begin
`ifdef DISTORTION_PIPE_SOFTCLIP_EN
            if (r_s2_x >= F_P) begin
               w_y    = H_P;
               w_clip = 1'b1;
            end else if (r_s2_x <= -F_P) begin
               w_y    = -F_P;
               w_clip = 1'b1;
            end else begin
               w_y    = P_W'(w_soft);
               w_clip = 1'b0;
            end
`else
            {w_clip, w_y} = f_clamp(r_s2_x, -F_P, H_P);
`endif
         end
         M_ASYM: begin
            {w_clip, w_y} = f_clamp(r_s2_x, -HALF_P, H_P);
         end
         default: begin
            w_y    = P_W'(r_s2_raw);
            w_clip = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3_v <= 1'b0;
      end else begin
         r_s3_v <= r_s2_v;
      end
   end

   always_ff @(posedge clk) begin
      if (r_s2_v) begin
         r_s3_y    <= DATA_W'(w_y);
         r_s3_clip <= w_clip;
      end
   end

   // ---------------- S4: output and clip counter ----------------
   logic                     r_out_v;
   logic signed [DATA_W-1:0] r_out_y;
   logic [CNT_W-1:0]         r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_v <= 1'b0;
         r_out_y <= '0;
         r_cnt   <= '0;
      end else begin
         r_out_v <= r_s3_v;
         if (r_s3_v) begin
            r_out_y <= r_s3_y;
         end
         // counter moves on the same edge the clipped sample is presented
         if (clear_count) begin
            r_cnt <= '0;
         end else if (r_s3_v && r_s3_clip && r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign out_valid  = r_out_v;
   assign out_sample = r_out_y;
   assign gain_now   = r_g;
   assign clip_count = r_cnt;

endmodule

// File: tb/tb_distortion_pipe.sv
// tb_distortion_pipe: directed vectors with a queue scoreboard; a monitor
// pops and checks sample, latency and clip count on every out_valid.

module tb_distortion_pipe;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic signed [15:0] in_sample;
   logic signed [15:0] gain_target;
   logic [1:0]         mode;
   logic               clear_count;
   logic               out_valid;
   logic signed [15:0] out_sample;
   logic signed [15:0] gain_now;
   logic [15:0]        clip_count;

   always #5 clk = ~clk;

   distortion_pipe #(
      .DATA_W(16), .FRAC_BITS(12), .GAIN_W(16),
      .RAMP_SHIFT(2), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_sample(in_sample), .gain_target(gain_target),
      .mode(mode), .clear_count(clear_count),
      .out_valid(out_valid), .out_sample(out_sample),
      .gain_now(gain_now), .clip_count(clip_count)
   );

   typedef struct {
      logic signed [15:0] y;
      bit                 clip;
      int                 stamp;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   mcnt    = 0;

`ifdef DISTORTION_PIPE_SOFTCLIP_EN
   localparam int SOFT_P2048 = 2816;
   localparam int SOFT_N2048 = -2816;
   localparam int SOFT_P1024 = 1504;
`else
   localparam int SOFT_P2048 = 2048;
   localparam int SOFT_N2048 = -2048;
   localparam int SOFT_P1024 = 1024;
`endif

   task automatic chk(input string name, input longint act,
                      input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // monitor / scoreboard
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected out_valid", 1, 0);
            end else begin
               e = q.pop_front();
               chk("out_sample", out_sample, e.y);
               chk("latency", cyc, e.stamp);
               if (e.clip && mcnt < 65535) mcnt++;
            end
         end
         if (rst || clear_count) mcnt = 0;
         if (out_valid) chk("clip_count", clip_count, mcnt);
      end
   end

   task automatic send(input logic [1:0] m, input int s, input int y,
                       input bit c);
      exp_t t;
      @(negedge clk);
      in_valid  = 1'b1;
      mode      = m;
      in_sample = 16'(s);
      t.y     = 16'(y);
      t.clip  = c;
      t.stamp = cyc + 4;
      q.push_back(t);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid    = 1'b0;
      clear_count = 1'b0;
      rst         = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("reset out_valid", out_valid, 0);
      chk("reset out_sample", out_sample, 0);
      chk("reset clip_count", clip_count, 0);
      chk("reset gain_now", gain_now, 4096);
   endtask

   int gexp[4] = '{5120, 5888, 6464, 6896};
   int rin[4]  = '{1000, 1000, -1000, 1000};
   int rout[4] = '{1000, 1250, -1438, 1578};
   int gprev;
   int w;

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_sample   = '0;
      gain_target = 16'sd4096;
      mode        = 2'd0;
      clear_count = 1'b0;
      repeat (3) @(negedge clk);
      do_reset();

      // gain ramp towards 8192 with shift 2
      gain_target = 16'sd8192;
      for (int i = 0; i < 4; i++) begin
         send(2'd1, rin[i], rout[i], 1'b0);
         idle(1);
         chk("gain_now ramp", gain_now, gexp[i]);
      end
      idle(5);
      chk("gain hold w/o valid", gain_now, 6896);
      gprev = 6896;
      for (int i = 0; i < 40; i++) begin
         send(2'd0, i * 7, i * 7, 1'b0);
         idle(1);
         chk("gain monotonic bounded",
             (gain_now >= gprev && gain_now <= 8192), 1);
         gprev = gain_now;
      end
      chk("gain reaches target", gain_now, 8192);
      for (int i = 0; i < 5; i++) send(2'd0, -i, -i, 1'b0);
      idle(6);
      chk("gain stays at target", gain_now, 8192);

      do_reset();
      gain_target = 16'sd4096;

      // hard clip, unity gain
      send(2'd1, 1000, 1000, 1'b0);
      send(2'd1, 5000, 4095, 1'b1);
      send(2'd1, -5000, -4096, 1'b1);
      idle(5);
      chk("clip_count hard", clip_count, 2);
      send(2'd1, 4095, 4095, 1'b0);
      send(2'd1, -4096, -4096, 1'b0);
      send(2'd1, 4096, 4095, 1'b1);

      // soft clip
      send(2'd2, 2048, SOFT_P2048, 1'b0);
      send(2'd2, 4096, 4095, 1'b1);
      send(2'd2, 0, 0, 1'b0);
      idle(5);
      chk("clip_count soft", clip_count, 4);
      send(2'd2, -2048, SOFT_N2048, 1'b0);
      send(2'd2, 1024, SOFT_P1024, 1'b0);

      // asymmetric, back to back with mode changes
      send(2'd3, -3000, -2048, 1'b1);
      send(2'd3, -2048, -2048, 1'b0);
      send(2'd3, -2049, -2048, 1'b1);
      send(2'd3, 5000, 4095, 1'b1);

      // bypass ignores gain
      gain_target = 16'sd8192;
      send(2'd0, 3000, 3000, 1'b0);
      send(2'd0, -32768, -32768, 1'b0);
      idle(6);
      chk("clip_count after bypass", clip_count, 7);

      do_reset();
      gain_target = 16'sd4096;

      // counter saturation
      for (int i = 0; i < 70000; i++) send(2'd1, 5000, 4095, 1'b1);
      idle(6);
      chk("clip_count saturated", clip_count, 65535);

      // clear on the clipping output cycle
      send(2'd1, 5000, 4095, 1'b1);
      idle(3);
      clear_count = 1'b1;
      @(negedge clk);
      clear_count = 1'b0;
      chk("clear beats increment", clip_count, 0);
      send(2'd1, -5000, -4096, 1'b1);
      idle(6);
      chk("count resumes", clip_count, 1);

      // reset mid-stream
      send(2'd1, 100, 100, 1'b0);
      send(2'd1, 200, 200, 1'b0);
      send(2'd1, 300, 300, 1'b0);
      do_reset();
      send(2'd1, 1234, 1234, 1'b0);
      idle(1);

      w = 0;
      while (q.size() > 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard drained", q.size(), 0);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
